// File: rtl/serial_add_pkg.sv
// Shared types and defaults for the bit-serial adder controller.
// The optional SERIAL_ADD_OVF_EN build adds a signed-overflow output.
package serial_add_pkg;

    // Default operand/result width. Legal widths are 2..32.
    localparam int DEF_W = 8;

    // Controller states. The encoding is fixed so the state can be decoded off-chip if needed.
    typedef enum logic [1:0] {
        IDLE = 2'b00,
        RUN  = 2'b01,
        DONE = 2'b10
    } state_e;

endpackage

// File: rtl/serial_add_ctrl_if.sv
// Requester-side bundle for serial_add_ctrl: start/done handshake, operands, result.
// The ovf signal exists only when SERIAL_ADD_OVF_EN is defined.
interface serial_add_ctrl_if
    import serial_add_pkg::*;
#(
    parameter int W = DEF_W
) ();

    logic         start;
    logic [W-1:0] op_a;
    logic [W-1:0] op_b;
    logic         cin;
    logic         busy;
    logic         done;
    logic [W-1:0] sum;
    logic         cout;
`ifdef SERIAL_ADD_OVF_EN
    logic         ovf;

    modport master (output start, op_a, op_b, cin,
                    input  busy, done, sum, cout, ovf);
    modport slave  (input  start, op_a, op_b, cin,
                    output busy, done, sum, cout, ovf);
`else
    modport master (output start, op_a, op_b, cin,
                    input  busy, done, sum, cout);
    modport slave  (input  start, op_a, op_b, cin,
                    output busy, done, sum, cout);
`endif

endinterface

// File: rtl/serial_add_ctrl_fulladdr.sv
// FULLADDR: the shared 1-bit full-adder cell. It is purely combinational.
module FULLADDR (
    output logic Cout,
    output logic Sum,
    input  logic Ain,
    input  logic Bin,
    input  logic Cin
);

    assign Sum  = Ain ^ Bin ^ Cin;
    assign Cout = (Ain & Bin) | (Cin & (Ain ^ Bin));

endmodule

// File: rtl/serial_add_ctrl.sv
// serial_add_ctrl: adds two W-bit operands one bit per cycle, LSB first, using a
// single FULLADDR cell with a registered carry loop. A result takes W+1 cycles
// from accept to the done pulse.
// Optional feature: define SERIAL_ADD_OVF_EN to get a registered signed-overflow flag.
module serial_add_ctrl
    import serial_add_pkg::*;
#(
    parameter int W = DEF_W
) (
    input  logic              clk,
    input  logic              rst_n,
    serial_add_ctrl_if.slave  bus
);

    localparam int                CNT_W    = $clog2(W);
    localparam logic [CNT_W-1:0]  LAST_IDX = CNT_W'(W - 1);

    state_e           r_state;
    logic [W-1:0]     r_a_sr;
    logic [W-1:0]     r_b_sr;
    logic [W-1:0]     r_sum;
    logic [CNT_W-1:0] r_idx;
    logic             r_carry;
    logic             r_cout;
    logic             r_busy;
    logic             r_done;
`ifdef SERIAL_ADD_OVF_EN
    logic             r_ovf;
`endif

    logic             w_fa_sum;
    logic             w_fa_cout;

    // The single adder cell always sees the current LSBs and the carry loop.
    FULLADDR u_fa (
        .Cout (w_fa_cout),
        .Sum  (w_fa_sum),
        .Ain  (r_a_sr[0]),
        .Bin  (r_b_sr[0]),
        .Cin  (r_carry)
    );

    // Controller FSM together with the shift registers, carry loop and registered outputs.
    // NOTE: every register here uses <= so all of them update from the same pre-edge values.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state <= IDLE;
            r_a_sr  <= '0;
            r_b_sr  <= '0;
            r_sum   <= '0;
            r_idx   <= '0;
            r_carry <= 1'b0;
            r_cout  <= 1'b0;
            r_busy  <= 1'b0;
            r_done  <= 1'b0;
`ifdef SERIAL_ADD_OVF_EN
            r_ovf   <= 1'b0;
`endif
        end else begin
            case (r_state)
                IDLE, DONE: begin
                    r_done <= 1'b0;
                    if (bus.start) begin
                        r_a_sr  <= bus.op_a;
                        r_b_sr  <= bus.op_b;
                        r_carry <= bus.cin;
                        r_idx   <= '0;
                        r_sum   <= '0;
                        r_cout  <= 1'b0;
`ifdef SERIAL_ADD_OVF_EN
                        r_ovf   <= 1'b0;
`endif
                        r_busy  <= 1'b1;
                        r_state <= RUN;
                    end else begin
                        r_state <= IDLE;
                    end
                end
                RUN: begin
                    // Each new sum bit enters at the MSB, so bit i reaches sum[i] after W steps.
                    r_sum   <= {w_fa_sum, r_sum[W-1:1]};
                    r_carry <= w_fa_cout;
                    r_a_sr  <= r_a_sr >> 1;
                    r_b_sr  <= r_b_sr >> 1;
                    r_idx   <= r_idx + 1'b1;
                    if (r_idx == LAST_IDX) begin
                        r_cout  <= w_fa_cout;
`ifdef SERIAL_ADD_OVF_EN
                        // On the last bit the carry register holds the carry into the MSB.
                        r_ovf   <= r_carry ^ w_fa_cout;
`endif
                        r_busy  <= 1'b0;
                        r_done  <= 1'b1;
                        r_state <= DONE;
                    end
                end
                default: begin
                    r_busy  <= 1'b0;
                    r_done  <= 1'b0;
                    r_state <= IDLE;
                end
            endcase
        end
    end

    assign bus.busy = r_busy;
    assign bus.done = r_done;
    assign bus.sum  = r_sum;
    assign bus.cout = r_cout;
`ifdef SERIAL_ADD_OVF_EN
    assign bus.ovf  = r_ovf;
`endif

endmodule

// File: tb/tb_serial_add_ctrl.sv
// Testbench for serial_add_ctrl (W=4). The stimulus pushes the expected results into a
// scoreboard queue. An independent monitor pops one entry at every done pulse.
// Build with SERIAL_ADD_OVF_EN defined to also cover the overflow flag.
module tb_serial_add_ctrl;

    localparam int W = 4;

    typedef struct packed {
        logic [W-1:0] sum;
        logic         cout;
        logic         ovf;
    } exp_t;

    logic clk;
    logic rst_n;
    int   checks;
    int   errors;
    exp_t sb_q[$];

    serial_add_ctrl_if #(.W(W)) bus ();

    serial_add_ctrl #(.W(W)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus.slave)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string name, input longint act, input longint req);
        checks++;
        if (act != req) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d (t=%0t)", name, act, req, $time);
        end
    endtask

    // Reference: plain integer arithmetic. Overflow means the signed sum is outside the W-bit range.
    function automatic exp_t model(input logic [W-1:0] a, input logic [W-1:0] b, input logic c);
        exp_t   e;
        longint total;
        longint sa;
        longint sb;
        longint s;
        total  = longint'(a) + longint'(b) + longint'(c);
        e.sum  = W'(total);
        e.cout = total >= (longint'(1) << W);
        sa     = a[W-1] ? longint'(a) - (longint'(1) << W) : longint'(a);
        sb     = b[W-1] ? longint'(b) - (longint'(1) << W) : longint'(b);
        s      = sa + sb + longint'(c);
        e.ovf  = (s > (longint'(1) << (W - 1)) - 1) || (s < -(longint'(1) << (W - 1)));
        return e;
    endfunction

    // Monitor: each done pulse must match the oldest outstanding request.
    initial begin
        exp_t e;
        forever begin
            @(negedge clk);
            if (rst_n && bus.done) begin
                if (sb_q.size() == 0) begin
                    checks++;
                    errors++;
                    $display("FAIL unexpected_done: got done=1 expected no pending request (t=%0t)", $time);
                end else begin
                    e = sb_q.pop_front();
                    check("sum", longint'(bus.sum), longint'(e.sum));
                    check("cout", longint'(bus.cout), longint'(e.cout));
`ifdef SERIAL_ADD_OVF_EN
                    check("ovf", longint'(bus.ovf), longint'(e.ovf));
`endif
                end
            end
        end
    end

    task automatic drive(input logic [W-1:0] a, input logic [W-1:0] b, input logic c);
        bus.op_a = a;
        bus.op_b = b;
        bus.cin  = c;
    endtask

    // A single request: latency, busy length and output hold are checked here. Values are checked by the monitor.
    task automatic run_one(input logic [W-1:0] a, input logic [W-1:0] b, input logic c, input bit noise);
        int   cyc;
        int   busy_cnt;
        bit   seen;
        exp_t e;
        e = model(a, b, c);
        @(negedge clk);
        drive(a, b, c);
        bus.start = 1'b1;
        sb_q.push_back(e);
        cyc      = 0;
        busy_cnt = 0;
        seen     = 0;
        while (!seen && cyc < W + 8) begin
            @(negedge clk);
            cyc++;
            if (cyc == 1) bus.start = 1'b0;
            if (noise && cyc == 2) begin
                bus.start = 1'b1;
                drive(W'($urandom), W'($urandom), 1'($urandom));
            end
            if (noise && cyc == 3) bus.start = 1'b0;
            if (bus.busy) busy_cnt++;
            if (bus.done) seen = 1;
        end
        check("done_seen", longint'(seen), 1);
        check("latency", cyc, W + 1);
        check("busy_cycles", busy_cnt, W);
        check("busy_in_done", longint'(bus.busy), 0);
        @(negedge clk);
        check("done_pulse_width", longint'(bus.done), 0);
        check("sum_held", longint'(bus.sum), longint'(e.sum));
        check("cout_held", longint'(bus.cout), longint'(e.cout));
    endtask

    // start is held high through DONE, so the second request is accepted with no idle cycle in between.
    task automatic run_b2b(input logic [W-1:0] a1, input logic [W-1:0] b1,
                           input logic [W-1:0] a2, input logic [W-1:0] b2);
        int cyc;
        int d1;
        int d2;
        @(negedge clk);
        drive(a1, b1, 1'b0);
        bus.start = 1'b1;
        sb_q.push_back(model(a1, b1, 1'b0));
        @(negedge clk);
        drive(a2, b2, 1'b0);
        sb_q.push_back(model(a2, b2, 1'b0));
        cyc = 1;
        d1  = -1;
        d2  = -1;
        while (d2 < 0 && cyc < 3 * W + 8) begin
            if (bus.done) begin
                if (d1 < 0) d1 = cyc;
                else d2 = cyc;
            end
            if (d2 < 0) begin
                @(negedge clk);
                cyc++;
                if (d1 >= 0 && cyc == d1 + 1) begin
                    check("b2b_no_idle_busy", longint'(bus.busy), 1);
                    bus.start = 1'b0;
                end
            end
        end
        bus.start = 1'b0;
        check("b2b_first_latency", d1, W + 1);
        check("b2b_gap", d2 - d1, W + 1);
        @(negedge clk);
    endtask

    initial begin
        checks    = 0;
        errors    = 0;
        rst_n     = 1'b0;
        bus.start = 1'b0;
        drive('0, '0, 1'b0);
        #12;
        check("rst_busy", longint'(bus.busy), 0);
        check("rst_done", longint'(bus.done), 0);
        check("rst_sum", longint'(bus.sum), 0);
        check("rst_cout", longint'(bus.cout), 0);
`ifdef SERIAL_ADD_OVF_EN
        check("rst_ovf", longint'(bus.ovf), 0);
`endif
        @(negedge clk);
        rst_n = 1'b1;
        repeat (2) @(negedge clk);

        // Directed cases.
        run_one(4'd3, 4'd5, 1'b0, 1'b0);
        run_one(4'd15, 4'd1, 1'b0, 1'b0);
        run_one(4'd0, 4'd0, 1'b1, 1'b0);
        run_one(4'd9, 4'd4, 1'b0, 1'b1);

        // Asynchronous reset during RUN: outputs clear at once, and the aborted request never completes.
        @(negedge clk);
        drive(4'd3, 4'd4, 1'b0);
        bus.start = 1'b1;
        @(negedge clk);
        bus.start = 1'b0;
        @(negedge clk);
        #2 rst_n = 1'b0;
        #1;
        check("abort_busy", longint'(bus.busy), 0);
        check("abort_done", longint'(bus.done), 0);
        check("abort_sum", longint'(bus.sum), 0);
        check("abort_cout", longint'(bus.cout), 0);
        @(negedge clk);
        rst_n = 1'b1;
        repeat (W + 3) @(negedge clk);
        check("abort_idle_busy", longint'(bus.busy), 0);
        run_one(4'd6, 4'd6, 1'b0, 1'b0);

        run_b2b(4'd7, 4'd7, 4'd1, 4'd2);

`ifdef SERIAL_ADD_OVF_EN
        run_one(4'd7, 4'd1, 1'b0, 1'b0);
        run_one(4'd8, 4'd15, 1'b0, 1'b0);
        run_one(4'd2, 4'd3, 1'b0, 1'b0);
`endif

        // Random requests, some with ignored mid-RUN start pulses, and some back-to-back pairs.
        for (int i = 0; i < 40; i++) begin
            run_one(W'($urandom), W'($urandom), 1'($urandom), 1'($urandom));
            repeat ($urandom_range(0, 2)) @(negedge clk);
        end
        for (int i = 0; i < 6; i++) begin
            run_b2b(W'($urandom), W'($urandom), W'($urandom), W'($urandom));
        end

        repeat (W + 3) @(negedge clk);
        check("scoreboard_drained", sb_q.size(), 0);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

    // Global watchdog so a stuck design cannot hang the run.
    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

endmodule
